instr_issue_queue: RTL and testbench



---
 rtl/issue_pkg.sv | 30 +++
 rtl/issue_hazard_sb.sv | 35 +++
 rtl/instr_issue_queue.sv | 75 +++++++
 tb/tb_instr_issue_queue.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// issue_pkg: instruction word layout shared by the issue queue and stage_one decode
package issue_pkg;
  localparam int IW = 32;
  localparam int RW = 5;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int WE_BIT = 30;
  localparam int DS_BIT = 29;
  localparam int ALU_HI = 28;
  localparam int ALU_LO = 26;
  localparam int WS_HI = 25;
  localparam int WS_LO = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam logic [IW-1:0] NOP = '0;
  typedef logic [RW-1:0] reg_t;
  function automatic reg_t f_ws(input logic [IW-1:0] i);
    return i[WS_HI:WS_LO];
  endfunction
  function automatic reg_t f_rs1(input logic [IW-1:0] i);
    return i[RS1_HI:RS1_LO];
  endfunction
  function automatic reg_t f_rs2(input logic [IW-1:0] i);
    return i[RS2_HI:RS2_LO];
  endfunction
endpackage

// File: rtl/issue_hazard_sb.sv
// issue_hazard_sb: in-flight destination register shift register and RAW match for the head word
module issue_hazard_sb
  import issue_pkg::*;
#(
  parameter int HAZ_DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  reg_t rs1,
  input  reg_t rs2,
  input  logic uses_rs2,
  input  logic push_v,
  input  reg_t push_ws,
  output logic hazard,
  output logic busy
);
  logic [HAZ_DEPTH-1:0] v;
  reg_t ws [HAZ_DEPTH];
  // newest issued write enters slot 0 every edge; the oldest falls off the end
  always_ff @(posedge clk) begin
    v[0] <= reset && push_v;
    ws[0] <= push_ws;
    for (int i = 1; i < HAZ_DEPTH; i++) begin
      v[i] <= reset && v[i-1];
      ws[i] <= ws[i-1];
    end
  end
  // any live write to a register the head reads blocks issue
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++)
      hazard = hazard | (v[i] && (ws[i] == rs1 || (uses_rs2 && ws[i] == rs2)));
  end
  assign busy = |v;
endmodule

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: in-order instruction FIFO with RAW interlock feeding stage_one; ISSUE_STATS_EN adds issue/bubble counters
module instr_issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HAZ_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [IW-1:0]           in_instr,
  output logic                    in_ready,
  output logic [IW-1:0]           InstrOut,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    idle
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]             issue_cnt,
  output logic [15:0]             bubble_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [IW-1:0] head;
  logic full, empty, push, pop, hazard, sb_busy;
  assign head = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign in_ready = reset && !full;
  assign push = in_valid && in_ready;
  assign pop = !empty && !hazard;
  assign idle = empty && !sb_busy;
  issue_hazard_sb #(.HAZ_DEPTH(HAZ_DEPTH)) u_sb (
    .clk(clk),
    .reset(reset),
    .rs1(f_rs1(head)),
    .rs2(f_rs2(head)),
    .uses_rs2(!head[DS_BIT]),
    .push_v(pop && head[WE_BIT]),
    .push_ws(f_ws(head)),
    .hazard(hazard),
    .busy(sb_busy)
  );
  // storage is written only on accepted pushes and needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_instr;
  end
  // pointers, occupancy and the registered word to stage_one
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      InstrOut <= NOP;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      InstrOut <= pop ? head : NOP;
    end
  end
`ifdef ISSUE_STATS_EN
  // saturating counts of issued words and hazard-forced bubbles
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (pop && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 16'd1;
      if (!empty && hazard && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_issue_queue.sv
// tb_instr_issue_queue: scoreboard bench with a register-ready-time reference model
module tb_instr_issue_queue;
  localparam int DEPTH = 8;
  localparam int HAZ = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic in_ready, idle;
  logic [31:0] InstrOut;
  logic [3:0] count;
`ifdef ISSUE_STATS_EN
  logic [15:0] issue_cnt, bubble_cnt;
`endif
  always #5 clk = ~clk;
  instr_issue_queue #(.DEPTH(DEPTH), .HAZ_DEPTH(HAZ)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_instr(in_instr),
    .in_ready(in_ready),
    .InstrOut(InstrOut),
    .count(count),
    .idle(idle)
`ifdef ISSUE_STATS_EN
    ,
    .issue_cnt(issue_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );
  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  cnt;
    logic        rdy;
    logic        idl;
    logic [15:0] ic;
    logic [15:0] bc;
  } exp_t;
  exp_t exp_q[$];
  exp_t me;
  logic [31:0] mq[$];
  int rdy_at[32];
  int edge_n = 0;
  int m_ic = 0;
  int m_bc = 0;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask
  // One clock: drive inputs, predict post-edge state from register ready times, queue the prediction.
  // A write issued at edge k makes its register readable again at edge k+HAZ+1.
  task automatic step(input logic rn, input logic v, input logic [31:0] w);
    exp_t e;
    logic [31:0] h;
    int sz;
    bit ok, busy;
    #2;
    reset = rn;
    in_valid = v;
    in_instr = w;
    e = '0;
    if (!rn) begin
      mq.delete();
      foreach (rdy_at[r]) rdy_at[r] = 0;
      m_ic = 0;
      m_bc = 0;
    end else begin
      sz = mq.size();
      if (sz > 0) begin
        h = mq[0];
        ok = edge_n >= rdy_at[h[20:16]] && (h[29] || edge_n >= rdy_at[h[15:11]]);
        if (ok) begin
          e.instr = h;
          void'(mq.pop_front());
          if (h[30]) rdy_at[h[25:21]] = edge_n + HAZ + 1;
          if (m_ic < 65535) m_ic++;
        end else if (m_bc < 65535) m_bc++;
      end
      if (v && sz < DEPTH) mq.push_back(w);
    end
    busy = 0;
    foreach (rdy_at[r]) if (rdy_at[r] > edge_n + 1) busy = 1;
    e.cnt = 4'(mq.size());
    e.idl = mq.size() == 0 && !busy;
    e.rdy = rn && mq.size() < DEPTH;
    e.ic = 16'(m_ic);
    e.bc = 16'(m_bc);
    edge_n++;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask
  // monitor: InstrOut is presented every cycle, so each edge's prediction is checked at the following negedge
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("InstrOut", InstrOut, me.instr);
      chk("count", 32'(count), 32'(me.cnt));
      chk("in_ready", 32'(in_ready), 32'(me.rdy));
      chk("idle", 32'(idle), 32'(me.idl));
`ifdef ISSUE_STATS_EN
      chk("issue_cnt", 32'(issue_cnt), 32'(me.ic));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(me.bc));
`endif
    end
  end
  initial begin
    logic [31:0] w;
    logic rn, v;
    step(0, 0, '0);
    step(0, 0, '0);
    repeat (4) step(1, 0, '0);
    step(1, 1, 32'h48611000);
    step(1, 1, 32'h48830800);
    repeat (6) step(1, 0, '0);
    step(1, 1, 32'h48611000);
    step(1, 1, 32'h48A11000);
    repeat (4) step(1, 0, '0);
    step(1, 1, 32'h48611000);
    step(1, 1, 32'h68C11800);
    repeat (4) step(1, 0, '0);
    for (int i = 0; i < 14; i++) step(1, 1, 32'h48630800 | 32'(i));
    repeat (45) step(1, 0, '0);
    for (int i = 0; i < 6; i++) step(1, 1, 32'h48630800 | 32'(i + 32));
    step(0, 1, 32'h12345678);
    repeat (8) step(1, 0, '0);
    for (int i = 0; i < 800; i++) begin
      w = $urandom;
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      w[15:11] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) w = '0;
      rn = $urandom_range(0, 60) != 0;
      v = $urandom_range(0, 2) != 0;
      step(rn, v, w);
    end
    repeat (30) step(1, 0, '0);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
